// File: rtl/src_ctrl_pkg.sv
// rtl/src_ctrl_pkg.sv - shared types, opcodes, ALU codes and strobe indices for src_ctrl_unit
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SHR = 4'd2;
  localparam logic [3:0] ALU_SHL = 4'd3;
  localparam logic [3:0] ALU_ROR = 4'd4;
  localparam logic [3:0] ALU_ROL = 4'd5;
  localparam logic [3:0] ALU_AND = 4'd6;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  localparam int WR_REGFILE = 0;
  localparam int WR_HI      = 1;
  localparam int WR_LO      = 2;
  localparam int WR_Z       = 3;
  localparam int WR_PC      = 4;
  localparam int WR_MDR     = 5;
  localparam int WR_IR      = 6;
  localparam int WR_Y       = 7;
  localparam int WR_MAR     = 8;
  localparam int WR_MEM     = 9;
  localparam int WR_OUTPORT = 10;

  localparam int RD_REGFILE = 0;
  localparam int RD_HI      = 1;
  localparam int RD_LO      = 2;
  localparam int RD_Z_LO    = 3;
  localparam int RD_Z_HI    = 4;
  localparam int RD_PC      = 5;
  localparam int RD_MDR     = 6;
  localparam int RD_INPORT  = 7;
  localparam int RD_C       = 8;
  localparam int RD_MEM     = 9;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_MEM,
    CLS_R,
    CLS_IMM,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_BR,
    CLS_JR,
    CLS_IN,
    CLS_OUT,
    CLS_MFHI,
    CLS_MFLO,
    CLS_HALT
  } iclass_t;

  // Groups opcodes by their T3+ sequence; unknown opcodes fall through to nop.
  function automatic iclass_t op_class(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST:                    return CLS_MEM;
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:           return CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI:                return CLS_IMM;
      OP_MUL, OP_DIV:                          return CLS_MULDIV;
      OP_NEG, OP_NOT:                          return CLS_UNARY;
      OP_BR:                                   return CLS_BR;
      OP_JR:                                   return CLS_JR;
      OP_IN:                                   return CLS_IN;
      OP_OUT:                                  return CLS_OUT;
      OP_MFHI:                                 return CLS_MFHI;
      OP_MFLO:                                 return CLS_MFLO;
      OP_HALT:                                 return CLS_HALT;
      default:                                 return CLS_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_op(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/branch_cond_ff.sv
// rtl/branch_cond_ff.sv - branch condition flag, captured from the bus when enabled
module branch_cond_ff (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  cond,
  input  logic [31:0] bus,
  output logic        branch
);

  logic branch_q;
  logic branch_d;

  always_comb begin
    branch_d = branch_q;
    if (en) begin
      case (cond)
        2'b00:   branch_d = (bus == 32'd0);
        2'b01:   branch_d = (bus != 32'd0);
        2'b10:   branch_d = ~bus[31];
        default: branch_d = bus[31];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) branch_q <= 1'b0;
    else     branch_q <= branch_d;
  end

  assign branch = branch_q;

endmodule

// File: rtl/src_ctrl_unit.sv
// rtl/src_ctrl_unit.sv - multi-step CPU control sequencer; SRC_CTRL_CLK_DIV_EN enables the step divider
module src_ctrl_unit
  import src_ctrl_pkg::*;
#(
  parameter int CLK_DIV_RATIO = 4
) (
  input  logic        clk,
  input  logic        in_reset,
  input  logic        in_stop,
  input  logic [31:0] in_ir,
  input  logic [31:0] in_bus,
  output logic        out_run,
  output logic        out_clear,
  output logic        out_gra,
  output logic        out_grb,
  output logic        out_grc,
  output logic        out_ba_read,
  output logic [10:0] out_wr,
  output logic [9:0]  out_rd,
  output logic [3:0]  out_alu_opcode,
  output logic        out_div_reset,
  output logic        out_mdr_select,
  output logic        out_inc_pc,
  output logic        out_branch,
  output logic [3:0]  out_state
);

  state_t     state_q;
  state_t     state_d;
  logic       step;
  logic       con_write;
  logic [4:0] opcode;
  iclass_t    cls;
  logic       unused_ir;

  assign opcode    = in_ir[31:27];
  assign cls       = op_class(opcode);
  assign unused_ir = ^{in_ir[26:21], in_ir[18:0]};

`ifdef SRC_CTRL_CLK_DIV_EN
  logic [7:0] div_cnt_q;
  logic [7:0] div_cnt_d;

  assign step = (div_cnt_q == 8'(CLK_DIV_RATIO - 1));

  always_comb begin
    div_cnt_d = step ? 8'd0 : div_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) div_cnt_q <= 8'd0;
    else          div_cnt_q <= div_cnt_d;
  end
`else
  logic [7:0] unused_div_ratio;
  assign unused_div_ratio = 8'(CLK_DIV_RATIO);
  assign step = 1'b1;
`endif

  assign con_write = (state_q == S_T3) && (cls == CLS_BR);

  branch_cond_ff u_branch_cond_ff (
    .clk    (clk),
    .rst    (in_reset),
    .en     (con_write & step),
    .cond   (in_ir[20:19]),
    .bus    (in_bus),
    .branch (out_branch)
  );

  always_ff @(posedge clk or posedge in_reset) begin
    if (in_reset) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (step) begin
      case (state_q)
        S_RESET: state_d = S_T0;
        S_T0:    state_d = S_T1;
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3: begin
          case (cls)
            CLS_MEM, CLS_R, CLS_IMM, CLS_MULDIV,
            CLS_UNARY, CLS_BR:                   state_d = S_T4;
            CLS_HALT:                            state_d = S_HALT;
            default:                             state_d = S_T0;
          endcase
        end
        S_T4: begin
          case (cls)
            CLS_MEM, CLS_R, CLS_IMM,
            CLS_MULDIV, CLS_BR:                  state_d = S_T5;
            default:                             state_d = S_T0;
          endcase
        end
        S_T5: begin
          if ((cls == CLS_MULDIV) || (cls == CLS_BR) ||
              ((cls == CLS_MEM) && (opcode != OP_LDI)))
            state_d = S_T6;
          else
            state_d = S_T0;
        end
        S_T6:    state_d = (cls == CLS_MEM) ? S_T7 : S_T0;
        S_T7:    state_d = S_T0;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RESET;
      endcase
      // A stop request wins over whatever the sequence would do next.
      if (in_stop) state_d = S_HALT;
    end
  end

  always_comb begin
    out_run        = (state_q != S_RESET) && (state_q != S_HALT);
    out_clear      = (state_q == S_RESET);
    out_gra        = 1'b0;
    out_grb        = 1'b0;
    out_grc        = 1'b0;
    out_ba_read    = 1'b0;
    out_wr         = '0;
    out_rd         = '0;
    out_alu_opcode = ALU_ADD;
    out_div_reset  = 1'b0;
    out_mdr_select = 1'b0;
    out_inc_pc     = 1'b0;
    out_state      = state_q;
    case (state_q)
      S_T0: begin
        out_rd[RD_PC]   = 1'b1;
        out_wr[WR_MAR]  = 1'b1;
        out_inc_pc      = 1'b1;
      end
      S_T1: begin
        out_rd[RD_MEM]  = 1'b1;
        out_mdr_select  = 1'b1;
        out_wr[WR_MDR]  = 1'b1;
      end
      S_T2: begin
        out_rd[RD_MDR]  = 1'b1;
        out_wr[WR_IR]   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_R, CLS_IMM: begin
            out_grb = 1'b1; out_rd[RD_REGFILE] = 1'b1; out_wr[WR_Y] = 1'b1;
          end
          CLS_UNARY: begin
            out_grb = 1'b1; out_rd[RD_REGFILE] = 1'b1;
            out_alu_opcode = alu_op(opcode); out_wr[WR_Z] = 1'b1;
          end
          CLS_MULDIV: begin
            out_gra = 1'b1; out_rd[RD_REGFILE] = 1'b1; out_wr[WR_Y] = 1'b1;
            out_div_reset = (opcode == OP_DIV);
          end
          CLS_MEM: begin
            out_grb = 1'b1; out_ba_read = 1'b1;
            out_rd[RD_REGFILE] = 1'b1; out_wr[WR_Y] = 1'b1;
          end
          CLS_BR: begin
            out_gra = 1'b1; out_rd[RD_REGFILE] = 1'b1;
          end
          CLS_JR: begin
            out_gra = 1'b1; out_rd[RD_REGFILE] = 1'b1; out_wr[WR_PC] = 1'b1;
          end
          CLS_IN: begin
            out_rd[RD_INPORT] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end
          CLS_OUT: begin
            out_gra = 1'b1; out_rd[RD_REGFILE] = 1'b1; out_wr[WR_OUTPORT] = 1'b1;
          end
          CLS_MFHI: begin
            out_rd[RD_HI] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end
          CLS_MFLO: begin
            out_rd[RD_LO] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_R: begin
            out_grc = 1'b1; out_rd[RD_REGFILE] = 1'b1;
            out_alu_opcode = alu_op(opcode); out_wr[WR_Z] = 1'b1;
          end
          CLS_IMM: begin
            out_rd[RD_C] = 1'b1; out_alu_opcode = alu_op(opcode); out_wr[WR_Z] = 1'b1;
          end
          CLS_UNARY: begin
            out_rd[RD_Z_LO] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end
          CLS_MULDIV: begin
            out_grb = 1'b1; out_rd[RD_REGFILE] = 1'b1;
            out_alu_opcode = alu_op(opcode); out_wr[WR_Z] = 1'b1;
          end
          CLS_MEM: begin
            out_rd[RD_C] = 1'b1; out_alu_opcode = ALU_ADD; out_wr[WR_Z] = 1'b1;
          end
          CLS_BR: begin
            out_rd[RD_PC] = 1'b1; out_wr[WR_Y] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_R, CLS_IMM: begin
            out_rd[RD_Z_LO] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end
          CLS_MULDIV: begin
            out_rd[RD_Z_LO] = 1'b1; out_wr[WR_LO] = 1'b1;
          end
          CLS_MEM: begin
            out_rd[RD_Z_LO] = 1'b1;
            if (opcode == OP_LDI) begin
              out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
            end else begin
              out_wr[WR_MAR] = 1'b1;
            end
          end
          CLS_BR: begin
            out_rd[RD_C] = 1'b1; out_alu_opcode = ALU_ADD; out_wr[WR_Z] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_MULDIV: begin
            out_rd[RD_Z_HI] = 1'b1; out_wr[WR_HI] = 1'b1;
          end
          CLS_MEM: begin
            if (opcode == OP_LD) begin
              out_rd[RD_MEM] = 1'b1; out_mdr_select = 1'b1; out_wr[WR_MDR] = 1'b1;
            end else if (opcode == OP_ST) begin
              out_gra = 1'b1; out_rd[RD_REGFILE] = 1'b1; out_wr[WR_MDR] = 1'b1;
            end
          end
          CLS_BR: begin
            out_rd[RD_Z_LO] = out_branch;
            out_wr[WR_PC]   = out_branch;
          end
          default: ;
        endcase
      end
      S_T7: begin
        if (cls == CLS_MEM) begin
          if (opcode == OP_LD) begin
            out_rd[RD_MDR] = 1'b1; out_gra = 1'b1; out_wr[WR_REGFILE] = 1'b1;
          end else if (opcode == OP_ST) begin
            out_wr[WR_MEM] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_src_ctrl_unit.sv
// tb/tb_src_ctrl_unit.sv - directed self-checking bench for src_ctrl_unit
module tb_src_ctrl_unit;

`ifdef SRC_CTRL_CLK_DIV_EN
  localparam int STEP = 4;
`else
  localparam int STEP = 1;
`endif

  logic        clk = 1'b0;
  logic        in_reset = 1'b1;
  logic        in_stop = 1'b0;
  logic [31:0] in_ir = 32'd0;
  logic [31:0] in_bus = 32'd0;
  logic        out_run, out_clear, out_gra, out_grb, out_grc, out_ba_read;
  logic [10:0] out_wr;
  logic [9:0]  out_rd;
  logic [3:0]  out_alu_opcode;
  logic        out_div_reset, out_mdr_select, out_inc_pc, out_branch;
  logic [3:0]  out_state;

  int n_checks = 0;
  int n_errors = 0;

  src_ctrl_unit #(.CLK_DIV_RATIO(4)) dut (
    .clk            (clk),
    .in_reset       (in_reset),
    .in_stop        (in_stop),
    .in_ir          (in_ir),
    .in_bus         (in_bus),
    .out_run        (out_run),
    .out_clear      (out_clear),
    .out_gra        (out_gra),
    .out_grb        (out_grb),
    .out_grc        (out_grc),
    .out_ba_read    (out_ba_read),
    .out_wr         (out_wr),
    .out_rd         (out_rd),
    .out_alu_opcode (out_alu_opcode),
    .out_div_reset  (out_div_reset),
    .out_mdr_select (out_mdr_select),
    .out_inc_pc     (out_inc_pc),
    .out_branch     (out_branch),
    .out_state      (out_state)
  );

  always #5 clk = ~clk;

  logic [38:0] obs;
  assign obs = {out_run, out_clear, out_gra, out_grb, out_grc, out_ba_read, out_div_reset,
                out_mdr_select, out_inc_pc, out_branch, out_alu_opcode, out_state, out_wr, out_rd};

  function automatic logic [38:0] ev(input logic run, clr, gra, grb, grc, ba, dr, ms, inc, br,
                                     input logic [3:0] alu, input logic [3:0] st,
                                     input logic [10:0] wr, input logic [9:0] rd);
    return {run, clr, gra, grb, grc, ba, dr, ms, inc, br, alu, st, wr, rd};
  endfunction

  task automatic step();
    repeat (STEP) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_stop  = 1'b0;
    in_reset = 1'b1;
    @(posedge clk);
    #1;
    in_reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [38:0] e;
    in_ir = 32'h18000000;
    in_reset = 1'b1;
    @(posedge clk);
    #1;
    e = ev(0,1,0,0,0,0,0,0,0,0, 4'd0, 4'd0, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    in_reset = 1'b0;
    #1;
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL reset_released_step got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,1,0, 4'd0, 4'd1, 11'h100, 10'h020);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL reset_t0 got=%h exp=%h", obs, e); end
    step();
    #3;
    in_reset = 1'b1;
    #1;
    e = ev(0,1,0,0,0,0,0,0,0,0, 4'd0, 4'd0, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL reset_async got=%h exp=%h", obs, e); end
  endtask

  task automatic test_add();
    logic [38:0] e;
    in_ir = 32'h18000000;
    do_reset();
    step();
    e = ev(1,0,0,0,0,0,0,1,0,0, 4'd0, 4'd2, 11'h020, 10'h200);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_t1 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd3, 11'h040, 10'h040);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_t2 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,1,0,0,0,0,0,0, 4'd0, 4'd4, 11'h080, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_t3 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,1,0,0,0,0,0, 4'd0, 4'd5, 11'h008, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_t4 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,1,0,0,0,0,0,0,0, 4'd0, 4'd6, 11'h001, 10'h008);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_t5 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,1,0, 4'd0, 4'd1, 11'h100, 10'h020);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL add_back_t0 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_sub();
    logic [38:0] e;
    in_ir = 32'h20000000;
    do_reset();
    repeat (4) step();
    e = ev(1,0,0,0,1,0,0,0,0,0, 4'd1, 4'd5, 11'h008, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL sub_t4 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_branch();
    logic [38:0] e;
    in_ir  = 32'h90000000;
    in_bus = 32'd0;
    do_reset();
    repeat (3) step();
    e = ev(1,0,1,0,0,0,0,0,0,0, 4'd0, 4'd4, 11'h000, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL br_t3 got=%h exp=%h", obs, e); end
    step();
    in_bus = 32'd7;
    e = ev(1,0,0,0,0,0,0,0,0,1, 4'd0, 4'd5, 11'h080, 10'h020);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL br_t4_taken got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,0,1, 4'd0, 4'd6, 11'h008, 10'h100);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL br_t5 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,0,1, 4'd0, 4'd7, 11'h010, 10'h008);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL br_t6_taken got=%h exp=%h", obs, e); end

    in_bus = 32'd5;
    do_reset();
    repeat (6) step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd7, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL br_t6_not_taken got=%h exp=%h", obs, e); end

    in_ir  = 32'h90180000;
    in_bus = 32'h80000000;
    do_reset();
    repeat (4) step();
    n_checks++; if (out_branch !== 1'b1) begin n_errors++; $display("FAIL br_cond11 got=%b exp=1", out_branch); end

    in_ir  = 32'h90100000;
    do_reset();
    repeat (4) step();
    n_checks++; if (out_branch !== 1'b0) begin n_errors++; $display("FAIL br_cond10 got=%b exp=0", out_branch); end
    in_bus = 32'd0;
  endtask

  task automatic test_store();
    logic [38:0] e;
    in_ir = 32'h10000000;
    do_reset();
    repeat (3) step();
    e = ev(1,0,0,1,0,1,0,0,0,0, 4'd0, 4'd4, 11'h080, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL st_t3 got=%h exp=%h", obs, e); end
    repeat (2) step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd6, 11'h100, 10'h008);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL st_t5 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,1,0,0,0,0,0,0,0, 4'd0, 4'd7, 11'h020, 10'h001);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL st_t6 got=%h exp=%h", obs, e); end
    step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd8, 11'h200, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL st_t7 got=%h exp=%h", obs, e); end
    step();
    n_checks++; if (out_state !== 4'd1) begin n_errors++; $display("FAIL st_back_t0 got=%0d exp=1", out_state); end
  endtask

  task automatic test_halt();
    logic [38:0] e;
    in_ir = 32'hD0000000;
    do_reset();
    repeat (3) step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd4, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL halt_t3 got=%h exp=%h", obs, e); end
    step();
    e = ev(0,0,0,0,0,0,0,0,0,0, 4'd0, 4'd9, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL halt_enter got=%h exp=%h", obs, e); end
    in_ir = 32'h18000000;
    repeat (5) step();
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL halt_stays got=%h exp=%h", obs, e); end
    in_reset = 1'b1;
    #1;
    n_checks++; if (out_clear !== 1'b1) begin n_errors++; $display("FAIL halt_exit_reset got=%b exp=1", out_clear); end
  endtask

  task automatic test_stop();
    logic [38:0] e;
    in_ir = 32'h00000000;
    do_reset();
    repeat (4) step();
    e = ev(1,0,0,0,0,0,0,0,0,0, 4'd0, 4'd5, 11'h008, 10'h100);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL ld_t4 got=%h exp=%h", obs, e); end
    in_stop = 1'b1;
    step();
    in_stop = 1'b0;
    e = ev(0,0,0,0,0,0,0,0,0,0, 4'd0, 4'd9, 11'h000, 10'h000);
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL stop_halt got=%h exp=%h", obs, e); end
    step();
    n_checks++; if (obs !== e) begin n_errors++; $display("FAIL stop_stays got=%h exp=%h", obs, e); end
  endtask

`ifdef SRC_CTRL_CLK_DIV_EN
  task automatic test_clk_div();
    logic [38:0] e;
    in_ir = 32'h18000000;
    do_reset();
    e = ev(1,0,0,0,0,0,0,0,1,0, 4'd0, 4'd1, 11'h100, 10'h020);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (obs !== e) begin n_errors++; $display("FAIL div_hold_%0d got=%h exp=%h", i, obs, e); end
    end
    @(posedge clk);
    #1;
    n_checks++; if (out_state !== 4'd2) begin n_errors++; $display("FAIL div_advance got=%0d exp=2", out_state); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_branch();
    test_store();
    test_halt();
    test_stop();
`ifdef SRC_CTRL_CLK_DIV_EN
    test_clk_div();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
